// File: rtl/ysyx_22050039_mem_pkg.sv
// ysyx_22050039_mem_pkg
//   Shared types and constants for the IFU/LSU memory arbiter.
//   XLEN / MASK_W : address/data width and byte write-mask width.
//   arb_state_e   : arbiter FSM states.
//   owner_e       : which requester owns the in-flight transaction.
//   GNT_IFU/GNT_LSU : bit positions in the 2-bit valid/grant vectors.
package ysyx_22050039_mem_pkg;

  localparam int XLEN   = 64;
  localparam int MASK_W = XLEN / 8;

  localparam int GNT_IFU = 0;
  localparam int GNT_LSU = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } owner_e;

  // One-hot grant to owner; an all-zero grant maps to IFU and is never
  // consumed because callers only use it when a grant is present.
  function automatic owner_e grant_to_owner(input logic [1:0] gnt);
    return gnt[GNT_LSU] ? OWN_LSU : OWN_IFU;
  endfunction

endpackage

// File: rtl/ysyx_22050039_arb2.sv
// ysyx_22050039_arb2
//   Two-way grant logic, purely combinational.
//   RR_EN = 0 : fixed priority, LSU (bit 1) over IFU (bit 0).
//   RR_EN = 1 : on a tie, grant the requester that was not served last.
//   A lone requester is always granted.
// Ports:
//   valid_i[1:0]  request vector {lsu, ifu}
//   last_grant_i  owner of the most recent grant (used only when RR_EN=1)
//   grant_o[1:0]  one-hot grant, zero when nothing is requested
module ysyx_22050039_arb2
  import ysyx_22050039_mem_pkg::*;
#(
  parameter bit RR_EN = 1'b0
) (
  input  logic [1:0] valid_i,
  input  owner_e     last_grant_i,
  output logic [1:0] grant_o
);

  logic [1:0] fixed_gnt;
  logic [1:0] rr_gnt;

  always_comb begin
    fixed_gnt = 2'b00;
    rr_gnt    = 2'b00;
    case (valid_i)
      2'b01: begin
        fixed_gnt = 2'b01;
        rr_gnt    = 2'b01;
      end
      2'b10: begin
        fixed_gnt = 2'b10;
        rr_gnt    = 2'b10;
      end
      2'b11: begin
        fixed_gnt = 2'b10;
        rr_gnt    = (last_grant_i == OWN_LSU) ? 2'b01 : 2'b10;
      end
      default: begin
        fixed_gnt = 2'b00;
        rr_gnt    = 2'b00;
      end
    endcase
    grant_o = RR_EN ? rr_gnt : fixed_gnt;
  end

endmodule

// File: rtl/ysyx_22050039_mem_arb.sv
// ysyx_22050039_mem_arb
//   Shares one memory port between the instruction fetch path (IFU, read
//   only) and the load/store path (LSU). One transaction is outstanding at a
//   time: accept in IDLE, present it to memory in ISSUE, wait for the
//   response in WAIT, then pulse the owner's resp_valid for one cycle.
//
// Configuration macros:
//   YSYX_22050039_ARB_RR_EN   round-robin tie-break instead of LSU > IFU.
//   YSYX_22050039_ARB_ASSERT  flag a memory response outside WAIT with $error.
//
// Ports:
//   clk, rst                 clock; synchronous active-low reset
//   ifu_req_*                fetch request (valid/ready/addr)
//   ifu_resp_*               fetch response pulse and data
//   lsu_req_*                load/store request (valid/ready/addr/wen/wdata/wmask)
//   lsu_resp_*               load data or store-done pulse (data 0 for stores)
//   mem_req_*                latched request towards the memory wrapper
//   mem_resp_*               memory read data / write ack
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no transaction; arbitrate and accept one request
// ISSUE | mem_req_valid high with latched fields, waiting mem_req_ready
// WAIT  | request taken by memory, waiting mem_resp_valid
module ysyx_22050039_mem_arb
  import ysyx_22050039_mem_pkg::*;
(
  input  logic              clk,
  input  logic              rst,

  input  logic              ifu_req_valid,
  output logic              ifu_req_ready,
  input  logic [XLEN-1:0]   ifu_req_addr,
  output logic              ifu_resp_valid,
  output logic [XLEN-1:0]   ifu_resp_data,

  input  logic              lsu_req_valid,
  output logic              lsu_req_ready,
  input  logic [XLEN-1:0]   lsu_req_addr,
  input  logic              lsu_req_wen,
  input  logic [XLEN-1:0]   lsu_req_wdata,
  input  logic [MASK_W-1:0] lsu_req_wmask,
  output logic              lsu_resp_valid,
  output logic [XLEN-1:0]   lsu_resp_data,

  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [XLEN-1:0]   mem_req_addr,
  output logic              mem_req_wen,
  output logic [XLEN-1:0]   mem_req_wdata,
  output logic [MASK_W-1:0] mem_req_wmask,
  input  logic              mem_resp_valid,
  input  logic [XLEN-1:0]   mem_resp_data
);

  arb_state_e        state_q, state_d;
  owner_e            owner_q, owner_d;

  logic              mem_req_valid_q, mem_req_valid_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic              wen_q, wen_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [MASK_W-1:0] wmask_q, wmask_d;

  logic              ifu_resp_valid_q, ifu_resp_valid_d;
  logic [XLEN-1:0]   ifu_resp_data_q, ifu_resp_data_d;
  logic              lsu_resp_valid_q, lsu_resp_valid_d;
  logic [XLEN-1:0]   lsu_resp_data_q, lsu_resp_data_d;

  logic [1:0]        req_vec;
  logic [1:0]        grant;
  owner_e            last_grant;

  assign req_vec = {lsu_req_valid, ifu_req_valid};

`ifdef YSYX_22050039_ARB_RR_EN
  localparam bit RR_EN = 1'b1;

  owner_e last_q, last_d;

  assign last_grant = last_q;

  // The pointer follows every grant, including uncontested ones, so a tie
  // always goes to whoever was not served by the previous transaction.
  always_comb begin
    last_d = last_q;
    if (state_q == IDLE && grant != 2'b00) begin
      last_d = grant_to_owner(grant);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      last_q <= OWN_IFU;
    end else begin
      last_q <= last_d;
    end
  end
`else
  localparam bit RR_EN = 1'b0;

  assign last_grant = OWN_IFU;
`endif

  ysyx_22050039_arb2 #(
    .RR_EN(RR_EN)
  ) u_arb2 (
    .valid_i     (req_vec),
    .last_grant_i(last_grant),
    .grant_o     (grant)
  );

  always_comb begin
    state_d          = state_q;
    owner_d          = owner_q;
    mem_req_valid_d  = mem_req_valid_q;
    addr_d           = addr_q;
    wen_d            = wen_q;
    wdata_d          = wdata_q;
    wmask_d          = wmask_q;
    ifu_resp_valid_d = 1'b0;
    ifu_resp_data_d  = ifu_resp_data_q;
    lsu_resp_valid_d = 1'b0;
    lsu_resp_data_d  = lsu_resp_data_q;
    ifu_req_ready    = 1'b0;
    lsu_req_ready    = 1'b0;

    case (state_q)
      IDLE: begin
        if (grant[GNT_LSU]) begin
          lsu_req_ready   = 1'b1;
          owner_d         = OWN_LSU;
          addr_d          = lsu_req_addr;
          wen_d           = lsu_req_wen;
          wdata_d         = lsu_req_wdata;
          // Loads never drive a byte mask towards memory.
          wmask_d         = lsu_req_wen ? lsu_req_wmask : '0;
          mem_req_valid_d = 1'b1;
          state_d         = ISSUE;
        end else if (grant[GNT_IFU]) begin
          ifu_req_ready   = 1'b1;
          owner_d         = OWN_IFU;
          addr_d          = ifu_req_addr;
          wen_d           = 1'b0;
          wdata_d         = '0;
          wmask_d         = '0;
          mem_req_valid_d = 1'b1;
          state_d         = ISSUE;
        end
      end

      ISSUE: begin
        if (mem_req_ready) begin
          mem_req_valid_d = 1'b0;
          state_d         = WAIT;
        end
      end

      WAIT: begin
        if (mem_resp_valid) begin
          state_d = IDLE;
          if (owner_q == OWN_IFU) begin
            ifu_resp_valid_d = 1'b1;
            ifu_resp_data_d  = mem_resp_data;
          end else begin
            lsu_resp_valid_d = 1'b1;
            lsu_resp_data_d  = wen_q ? '0 : mem_resp_data;
          end
        end
      end

      default: begin
        state_d         = IDLE;
        mem_req_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q          <= IDLE;
      owner_q          <= OWN_IFU;
      mem_req_valid_q  <= 1'b0;
      addr_q           <= '0;
      wen_q            <= 1'b0;
      wdata_q          <= '0;
      wmask_q          <= '0;
      ifu_resp_valid_q <= 1'b0;
      ifu_resp_data_q  <= '0;
      lsu_resp_valid_q <= 1'b0;
      lsu_resp_data_q  <= '0;
    end else begin
      state_q          <= state_d;
      owner_q          <= owner_d;
      mem_req_valid_q  <= mem_req_valid_d;
      addr_q           <= addr_d;
      wen_q            <= wen_d;
      wdata_q          <= wdata_d;
      wmask_q          <= wmask_d;
      ifu_resp_valid_q <= ifu_resp_valid_d;
      ifu_resp_data_q  <= ifu_resp_data_d;
      lsu_resp_valid_q <= lsu_resp_valid_d;
      lsu_resp_data_q  <= lsu_resp_data_d;
    end
  end

  assign mem_req_valid  = mem_req_valid_q;
  assign mem_req_addr   = addr_q;
  assign mem_req_wen    = wen_q;
  assign mem_req_wdata  = wdata_q;
  assign mem_req_wmask  = wmask_q;
  assign ifu_resp_valid = ifu_resp_valid_q;
  assign ifu_resp_data  = ifu_resp_data_q;
  assign lsu_resp_valid = lsu_resp_valid_q;
  assign lsu_resp_data  = lsu_resp_data_q;

`ifdef YSYX_22050039_ARB_ASSERT
  // A response with no transaction waiting for it is a wrapper bug; the FSM
  // already ignores it, this just makes it visible.
  always_ff @(posedge clk) begin
    if (rst && state_q != WAIT) begin
      assert (!mem_resp_valid)
        else $error("mem_resp_valid outside WAIT (state=%0d)", state_q);
    end
  end
`endif

endmodule

// File: tb/tb_ysyx_22050039_mem_arb.sv
module tb_ysyx_22050039_mem_arb;
  import ysyx_22050039_mem_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              ifu_req_valid, ifu_req_ready;
  logic [XLEN-1:0]   ifu_req_addr;
  logic              ifu_resp_valid;
  logic [XLEN-1:0]   ifu_resp_data;
  logic              lsu_req_valid, lsu_req_ready;
  logic [XLEN-1:0]   lsu_req_addr;
  logic              lsu_req_wen;
  logic [XLEN-1:0]   lsu_req_wdata;
  logic [MASK_W-1:0] lsu_req_wmask;
  logic              lsu_resp_valid;
  logic [XLEN-1:0]   lsu_resp_data;
  logic              mem_req_valid, mem_req_ready;
  logic [XLEN-1:0]   mem_req_addr;
  logic              mem_req_wen;
  logic [XLEN-1:0]   mem_req_wdata;
  logic [MASK_W-1:0] mem_req_wmask;
  logic              mem_resp_valid;
  logic [XLEN-1:0]   mem_resp_data;

  ysyx_22050039_mem_arb dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
    .ifu_req_addr(ifu_req_addr), .ifu_resp_valid(ifu_resp_valid),
    .ifu_resp_data(ifu_resp_data),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
    .lsu_req_addr(lsu_req_addr), .lsu_req_wen(lsu_req_wen),
    .lsu_req_wdata(lsu_req_wdata), .lsu_req_wmask(lsu_req_wmask),
    .lsu_resp_valid(lsu_resp_valid), .lsu_resp_data(lsu_resp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_req_wen(mem_req_wen),
    .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    bit          lsu;
    logic [63:0] data;
  } exp_t;

  typedef struct {
    logic [63:0] addr;
    logic        wen;
    logic [63:0] wdata;
    logic [7:0]  wmask;
  } lsu_req_t;

  exp_t        sb[$];
  logic [63:0] ifu_q[$];
  lsu_req_t    lsu_q[$];
  int          ifu_acc_hist[$];
  int          lsu_acc_hist[$];
  int          resp_cnt = 0;

  int stall_cfg   = 0;
  int stall_left  = 0;
  bit hold_resp   = 1'b0;
  bit inject_late = 1'b0;

  // Memory contents: a fixed function of the address; 0x8000_0000 holds
  // 0x00100073_00000413.
  function automatic logic [63:0] rdata(input logic [63:0] a);
    return a ^ 64'h0010_0073_8000_0413;
  endfunction

  // IFU requester: holds valid until accepted, pushes expectation at accept.
  initial begin : ifu_drv
    bit acc;
    acc = 1'b0;
    ifu_req_valid = 1'b0;
    ifu_req_addr  = '0;
    forever begin
      @(negedge clk);
      if (acc) begin
        ifu_req_valid = 1'b0;
        acc = 1'b0;
      end
      if (!ifu_req_valid && ifu_q.size() > 0 && rst) begin
        ifu_req_addr  = ifu_q.pop_front();
        ifu_req_valid = 1'b1;
      end
      #1;
      if (rst && ifu_req_valid && ifu_req_ready) begin
        acc = 1'b1;
        sb.push_back('{1'b0, rdata(ifu_req_addr)});
        ifu_acc_hist.push_back(cyc);
      end
    end
  end

  initial begin : lsu_drv
    bit acc;
    lsu_req_t r;
    acc = 1'b0;
    lsu_req_valid = 1'b0;
    lsu_req_addr  = '0;
    lsu_req_wen   = 1'b0;
    lsu_req_wdata = '0;
    lsu_req_wmask = '0;
    forever begin
      @(negedge clk);
      if (acc) begin
        lsu_req_valid = 1'b0;
        acc = 1'b0;
      end
      if (!lsu_req_valid && lsu_q.size() > 0 && rst) begin
        r = lsu_q.pop_front();
        lsu_req_addr  = r.addr;
        lsu_req_wen   = r.wen;
        lsu_req_wdata = r.wdata;
        lsu_req_wmask = r.wmask;
        lsu_req_valid = 1'b1;
      end
      #1;
      if (rst && lsu_req_valid && lsu_req_ready) begin
        acc = 1'b1;
        sb.push_back('{1'b1, lsu_req_wen ? 64'h0 : rdata(lsu_req_addr)});
        lsu_acc_hist.push_back(cyc);
      end
    end
  end

  // Memory model: optional stall on ready, response one cycle after handshake.
  initial begin : mem_model
    bit          hs;
    logic [63:0] hs_addr;
    hs = 1'b0;
    hs_addr = '0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    forever begin
      @(negedge clk);
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b0;
      mem_resp_data  = '0;
      if (!rst) begin
        hs = 1'b0;
      end else begin
        if (hs) begin
          hs = 1'b0;
          if (!hold_resp) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = rdata(hs_addr);
          end
        end else if (inject_late) begin
          inject_late    = 1'b0;
          mem_resp_valid = 1'b1;
          mem_resp_data  = 64'hbad0_bad0_bad0_bad0;
        end
        if (mem_req_valid) begin
          if (stall_left > 0) begin
            stall_left = stall_left - 1;
          end else begin
            mem_req_ready = 1'b1;
            hs      = 1'b1;
            hs_addr = mem_req_addr;
            stall_left = stall_cfg;
          end
        end
      end
    end
  end

  // Scoreboard: every response pulse must match the oldest accepted request.
  initial begin : monitor
    exp_t        e;
    logic [63:0] got;
    forever begin
      @(negedge clk);
      #2;
      if (ifu_resp_valid === 1'b1 || lsu_resp_valid === 1'b1) begin
        resp_cnt++;
        checks++;
        if (ifu_resp_valid === 1'b1 && lsu_resp_valid === 1'b1) begin
          failures++;
          $display("FAIL resp_both: ifu_v=1 lsu_v=1, required only one");
        end
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL resp_unexpected: ifu_v=%0b lsu_v=%0b, required no response",
                   ifu_resp_valid, lsu_resp_valid);
        end else begin
          e = sb.pop_front();
          got = e.lsu ? lsu_resp_data : ifu_resp_data;
          checks++;
          if ((e.lsu ? lsu_resp_valid : ifu_resp_valid) !== 1'b1) begin
            failures++;
            $display("FAIL resp_owner: ifu_v=%0b lsu_v=%0b, required lsu=%0b",
                     ifu_resp_valid, lsu_resp_valid, e.lsu);
          end
          checks++;
          if (got !== e.data) begin
            failures++;
            $display("FAIL resp_data: got %h, required %h", got, e.data);
          end
        end
      end
    end
  end

  task automatic wait_drain(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #3;
      if (sb.size() == 0 && ifu_q.size() == 0 && lsu_q.size() == 0 &&
          !ifu_req_valid && !lsu_req_valid && !mem_req_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    checks++;
    if ({mem_req_valid, ifu_resp_valid, lsu_resp_valid} !== 3'b000) begin
      failures++;
      $display("FAIL reset_valids: got %b, required 000",
               {mem_req_valid, ifu_resp_valid, lsu_resp_valid});
    end
    checks++;
    if ({mem_req_addr, mem_req_wdata, mem_req_wmask, mem_req_wen} !== '0) begin
      failures++;
      $display("FAIL reset_mem_fields: addr=%h wdata=%h wmask=%h wen=%b, required 0",
               mem_req_addr, mem_req_wdata, mem_req_wmask, mem_req_wen);
    end
    checks++;
    if ({ifu_resp_data, lsu_resp_data} !== '0) begin
      failures++;
      $display("FAIL reset_resp_data: ifu=%h lsu=%h, required 0", ifu_resp_data, lsu_resp_data);
    end
    checks++;
    if ({ifu_req_ready, lsu_req_ready} !== 2'b00) begin
      failures++;
      $display("FAIL reset_ready: got %b, required 00", {ifu_req_ready, lsu_req_ready});
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_ifu_only();
    int acc_c, resp_c, base;
    logic [63:0] rd;
    bit ok;
    acc_c = -1; resp_c = -1; rd = '0;
    base = ifu_acc_hist.size();
    @(posedge clk); #1;
    ifu_q.push_back(64'h0000_0000_8000_0000);
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      #2;
      if (acc_c < 0 && ifu_acc_hist.size() > base) acc_c = ifu_acc_hist[base];
      checks++;
      if (lsu_resp_valid !== 1'b0) begin
        failures++;
        $display("FAIL ifu_only_lsu_quiet: lsu_resp_valid=%b, required 0", lsu_resp_valid);
      end
      if (mem_req_valid === 1'b1) begin
        checks++;
        if (mem_req_wen !== 1'b0 || mem_req_wmask !== 8'h00 ||
            mem_req_addr !== 64'h8000_0000) begin
          failures++;
          $display("FAIL ifu_only_mem_req: addr=%h wen=%b wmask=%h, required 80000000/0/00",
                   mem_req_addr, mem_req_wen, mem_req_wmask);
        end
      end
      if (ifu_resp_valid === 1'b1 && resp_c < 0) begin
        resp_c = cyc;
        rd = ifu_resp_data;
      end
    end
    checks++;
    if (acc_c < 0 || resp_c - acc_c != 3) begin
      failures++;
      $display("FAIL ifu_only_latency: accept=%0d resp=%0d, required resp-accept=3", acc_c, resp_c);
    end
    checks++;
    if (rd !== 64'h0010_0073_0000_0413) begin
      failures++;
      $display("FAIL ifu_only_data: got %h, required 0010007300000413", rd);
    end
    wait_drain(20, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL ifu_only_drain: timeout, required idle"); end
  endtask

  task automatic test_store();
    bit seen, lsu_seen, ok;
    logic [63:0] rd;
    seen = 1'b0; lsu_seen = 1'b0; rd = '1;
    @(posedge clk); #1;
    lsu_q.push_back('{64'h8000_2000, 1'b1, 64'h0000_0000_dead_beef, 8'h0f});
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      #2;
      if (mem_req_valid === 1'b1 && !seen) begin
        seen = 1'b1;
        checks++;
        if (mem_req_wen !== 1'b1 || mem_req_wmask !== 8'h0f ||
            mem_req_addr !== 64'h8000_2000 || mem_req_wdata !== 64'hdead_beef) begin
          failures++;
          $display("FAIL store_mem_req: addr=%h wen=%b wdata=%h wmask=%h, required 80002000/1/deadbeef/0f",
                   mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask);
        end
      end
      if (lsu_resp_valid === 1'b1 && !lsu_seen) begin
        lsu_seen = 1'b1;
        rd = lsu_resp_data;
      end
    end
    checks++;
    if (!seen || !lsu_seen || rd !== 64'h0) begin
      failures++;
      $display("FAIL store_resp: req_seen=%b resp_seen=%b data=%h, required 1/1/0", seen, lsu_seen, rd);
    end
    wait_drain(20, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL store_drain: timeout, required idle"); end
  endtask

  task automatic test_simultaneous();
    int bi, bl, t;
    bit ok;
    bi = ifu_acc_hist.size();
    bl = lsu_acc_hist.size();
    @(posedge clk); #1;
    ifu_q.push_back(64'h8000_0004);
    lsu_q.push_back('{64'h8000_1000, 1'b0, 64'h0, 8'h00});
    t = 0;
    while ((ifu_acc_hist.size() == bi || lsu_acc_hist.size() == bl) && t < 40) begin
      @(negedge clk); #2; t++;
    end
    checks++;
    if (t >= 40) begin
      failures++;
      $display("FAIL simul_accept: timeout, required both accepted");
    end else begin
`ifdef YSYX_22050039_ARB_RR_EN
      if (lsu_acc_hist[bl] - ifu_acc_hist[bi] != 3) begin
        failures++;
        $display("FAIL simul_order_rr: ifu_acc=%0d lsu_acc=%0d, required lsu = ifu+3",
                 ifu_acc_hist[bi], lsu_acc_hist[bl]);
      end
`else
      if (ifu_acc_hist[bi] - lsu_acc_hist[bl] != 3) begin
        failures++;
        $display("FAIL simul_order_fixed: ifu_acc=%0d lsu_acc=%0d, required ifu = lsu+3",
                 ifu_acc_hist[bi], lsu_acc_hist[bl]);
      end
`endif
    end
    wait_drain(30, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL simul_drain: timeout, required idle"); end
  endtask

  task automatic test_stall();
    int t, bl, n;
    bit ok;
    bl = lsu_acc_hist.size();
    stall_left = 5;
    stall_cfg  = 0;
    @(posedge clk); #1;
    lsu_q.push_back('{64'h8000_4010, 1'b1, 64'h0123_4567_89ab_cdef, 8'ha5});
    t = 0;
    while (lsu_acc_hist.size() == bl && t < 20) begin @(negedge clk); #2; t++; end
    ifu_q.push_back(64'h8000_0040);
    t = 0;
    while (mem_req_valid !== 1'b1 && t < 20) begin @(negedge clk); #2; t++; end
    checks++;
    if (t >= 20) begin failures++; $display("FAIL stall_issue: timeout, required mem_req_valid"); end
    n = 0;
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (mem_req_valid !== 1'b1 || mem_req_addr !== 64'h8000_4010 || mem_req_wen !== 1'b1 ||
          mem_req_wdata !== 64'h0123_4567_89ab_cdef || mem_req_wmask !== 8'ha5) begin
        failures++;
        $display("FAIL stall_fields c%0d: v=%b addr=%h wen=%b wdata=%h wmask=%h, required stable",
                 c, mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask);
      end
      checks++;
      if ({ifu_req_ready, lsu_req_ready} !== 2'b00 || ifu_req_valid !== 1'b1) begin
        failures++;
        $display("FAIL stall_ready c%0d: ready=%b ifu_valid=%b, required 00 with ifu_valid=1",
                 c, {ifu_req_ready, lsu_req_ready}, ifu_req_valid);
      end
      if (mem_req_ready === 1'b0) n++;
      @(negedge clk); #2;
    end
    checks++;
    if (n != 5) begin failures++; $display("FAIL stall_count: stalled %0d, required 5", n); end
    wait_drain(40, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL stall_drain: timeout, required idle"); end
  endtask

  task automatic test_back_to_back();
    int base, rbase, t;
    bit ok;
    base  = ifu_acc_hist.size();
    rbase = resp_cnt;
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) ifu_q.push_back(64'h8000_0100 + 64'(4 * i));
    wait_drain(80, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL b2b_drain: timeout, required idle"); end
    checks++;
    if (ifu_acc_hist.size() - base != 10 || resp_cnt - rbase != 10) begin
      failures++;
      $display("FAIL b2b_count: accepts=%0d resps=%0d, required 10/10",
               ifu_acc_hist.size() - base, resp_cnt - rbase);
    end else begin
      for (int i = 1; i < 10; i++) begin
        t = ifu_acc_hist[base + i] - ifu_acc_hist[base + i - 1];
        checks++;
        if (t != 3) begin
          failures++;
          $display("FAIL b2b_spacing %0d: got %0d cycles, required 3", i, t);
        end
      end
    end
  endtask

  task automatic test_reset_in_wait();
    int base, t;
    bit ok;
    base = ifu_acc_hist.size();
    hold_resp = 1'b1;
    @(posedge clk); #1;
    ifu_q.push_back(64'h8000_0200);
    t = 0;
    while (ifu_acc_hist.size() == base && t < 20) begin @(negedge clk); #2; t++; end
    @(negedge clk);
    @(negedge clk);
    #2;
    checks++;
    if (mem_req_valid !== 1'b0 || t >= 20) begin
      failures++;
      $display("FAIL rstwait_enter: mem_req_valid=%b timeout=%b, required 0/0", mem_req_valid, t >= 20);
    end
    rst = 1'b0;
    @(negedge clk);
    #2;
    checks++;
    if ({mem_req_valid, ifu_resp_valid, lsu_resp_valid, ifu_req_ready, lsu_req_ready} !== 5'b0 ||
        {mem_req_addr, mem_req_wdata, mem_req_wmask, mem_req_wen, ifu_resp_data, lsu_resp_data} !== '0) begin
      failures++;
      $display("FAIL rstwait_zero: mv=%b iv=%b lv=%b addr=%h idata=%h ldata=%h, required all 0",
               mem_req_valid, ifu_resp_valid, lsu_resp_valid, mem_req_addr, ifu_resp_data, lsu_resp_data);
    end
    sb.delete();
    rst = 1'b1;
    hold_resp = 1'b0;
    inject_late = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); #2;
      checks++;
      if ({ifu_resp_valid, lsu_resp_valid, mem_req_valid} !== 3'b000) begin
        failures++;
        $display("FAIL rstwait_late c%0d: iv=%b lv=%b mv=%b, required 000",
                 c, ifu_resp_valid, lsu_resp_valid, mem_req_valid);
      end
    end
    base = ifu_acc_hist.size();
    @(posedge clk); #1;
    ifu_q.push_back(64'h8000_0300);
    @(negedge clk); #2;
    checks++;
    if (ifu_acc_hist.size() != base + 1) begin
      failures++;
      $display("FAIL rstwait_idle: accepts=%0d, required immediate accept", ifu_acc_hist.size() - base);
    end
    wait_drain(20, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL rstwait_drain: timeout, required idle"); end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_ifu_only();
    test_store();
    test_simultaneous();
    test_stall();
    test_back_to_back();
    test_reset_in_wait();
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ysyx_22050039_mem_arb.md
Name: ysyx_22050039_mem_arb

Overview:
- Two-requester memory arbiter. It shares one memory port between the instruction fetch path (IFU, read-only) and the load/store path (LSU, read/write).
- It replaces the per-cycle direct pmem access of the single-cycle core with a sequenced, one-outstanding-transaction handshake.
- It sits between IFU/LSU and the memory wrapper, which is the DPI pmem bridge or a bus bridge later.

Parameters:
- XLEN, 64, address and data width.
- MASK_W, 8, byte write-mask width (XLEN/8).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-low.
- ifu_req_valid  in  1  IFU fetch request.
- ifu_req_ready  out  1  IFU request accepted this cycle.
- ifu_req_addr  in  XLEN  fetch address.
- ifu_resp_valid  out  1  one-cycle pulse: fetch data valid.
- ifu_resp_data  out  XLEN  fetched doubleword.
- lsu_req_valid  in  1  LSU request.
- lsu_req_ready  out  1  LSU request accepted this cycle.
- lsu_req_addr  in  XLEN  data address.
- lsu_req_wen  in  1  1 = store, 0 = load.
- lsu_req_wdata  in  XLEN  store data.
- lsu_req_wmask  in  MASK_W  store byte mask.
- lsu_resp_valid  out  1  one-cycle pulse: load data valid, or store done.
- lsu_resp_data  out  XLEN  load data; 0 for stores.
- mem_req_valid  out  1  request to memory.
- mem_req_ready  in  1  memory accepts request.
- mem_req_addr  out  XLEN  latched address.
- mem_req_wen  out  1  latched write enable.
- mem_req_wdata  out  XLEN  latched write data.
- mem_req_wmask  out  MASK_W  latched mask; 0 for reads.
- mem_resp_valid  in  1  memory response or write ack.
- mem_resp_data  in  XLEN  read data.

Behaviour:
- rst is synchronous, active-low, clock clk. When rst=0 at a posedge:
  - state <= IDLE;
  - all registered outputs <= 0 (mem_req_*, *_resp_valid, *_resp_data);
  - RR pointer <= IFU;
  - any in-flight transaction is dropped.
- FSM has three states: IDLE, ISSUE, WAIT. Owner register holds IFU or LSU.
- IDLE:
  - If any req_valid is high, pick a winner. Fixed priority: LSU > IFU.
  - Assert the winner's req_ready combinationally in the same cycle; the loser's ready stays 0.
  - Latch addr/wen/wdata/wmask and owner. Next state is ISSUE.
  - An IFU request latches wen=0 and wmask=0.
- ISSUE:
  - mem_req_valid=1 with the latched fields.
  - On mem_req_ready=1, go to WAIT. Otherwise hold; fields stay stable.
- WAIT:
  - On mem_resp_valid=1, register owner's resp_valid=1 for exactly one cycle, with resp_data=mem_resp_data. For stores, lsu_resp_data=0.
  - Next state is IDLE.
- Both req_ready outputs are 0 in ISSUE and WAIT.
- Minimum latency, accept to resp_valid, is 3 cycles: accept (c0), issue with ready (c1), mem_resp (c2), resp_valid (c3).
- Back-to-back: the IDLE cycle in which resp_valid is high may accept the next request.
- mem_resp_valid in IDLE or ISSUE is ignored. In the assertion build it triggers $error.
- Requester protocol: req_valid must be held until req_ready. Fields are captured at accept, so later changes are harmless.
- No response backpressure: requesters must consume resp_valid when it is asserted.
- Address and data pass through unmodified. No alignment or extraction; requesters select sub-words.

Optional Feature:
- Macro YSYX_22050039_ARB_RR_EN.
- Defined: round-robin arbitration. On simultaneous valid in IDLE, grant the requester not served last. The pointer updates on every grant.
- Undefined: fixed LSU > IFU priority; no pointer register.
- A single requester is granted immediately in both builds.

Decomposition:
- Shared package ysyx_22050039_mem_pkg holds:
  - state enum {IDLE, ISSUE, WAIT};
  - owner enum {OWN_IFU, OWN_LSU};
  - XLEN and MASK_W constants.
- Sub-module ysyx_22050039_arb2: a 2-way grant with fixed or RR policy, taking valid[1:0] and last_grant and producing a one-hot grant[1:0].

Test Plan:
- IFU only: ifu addr 0x8000_0000, mem ready at once, resp data 0x00100073_00000413 one cycle later. Expect ifu_resp_valid exactly 3 cycles after accept with that data, and lsu_resp_valid=0 throughout.
- Simultaneous IFU 0x8000_0004 and LSU load 0x8000_1000:
  - fixed build: LSU granted first, IFU ready only in the IDLE cycle of the LSU response;
  - RR build with last=LSU: IFU granted first.
- LSU store addr 0x8000_2000, wdata 0xdead_beef, mask 0x0f. Expect mem_req_wen=1 and mask 0x0f; after ack, lsu_resp_valid=1 and lsu_resp_data=0.
- mem_req_ready held low for 5 cycles. Expect mem_req_valid and fields stable throughout, and both req_ready=0.
- rst=0 asserted in WAIT, then released, then a late mem_resp_valid. Expect no resp_valid, state IDLE, and all outputs 0 the cycle after reset.
- Ten back-to-back IFU fetches with zero-wait memory. Expect one fetch every 3 cycles and no lost or duplicated responses.
